// File: rtl/mips_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// mips_fetch_unit_if
// Instruction-memory fetch bus between the fetch stage and instruction memory.
//   imem_req   : fetch request, held high until the memory answers
//   imem_addr  : byte address of the requested word, stable while requested
//   imem_rdata : instruction word, valid only while imem_ready is high
//   imem_ready : memory completes the fetch in this cycle
// The master modport is the fetch unit; the slave modport is the memory.
// -----------------------------------------------------------------------------
interface mips_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// mips_fetch_unit
// Instruction-fetch stage of the multicycle MIPS core. Holds the PC, fetches
// one 32-bit word per instruction over the imem req/ready handshake, latches
// it into the instruction register and, when control retires the instruction,
// selects the next PC (sequential, taken branch or jump).
//
// Ports:
//   clk            : system clock, rising edge
//   rst            : asynchronous, active-high reset
//   imem           : instruction-memory bus (master side)
//   i_instr_done   : one-cycle retire pulse from control
//   i_branch       : branch instruction in flight
//   i_jump         : jump instruction in flight
//   i_zero         : ALU zero flag
//   o_opcode       : instruction register
//   o_instr_valid  : o_opcode holds a fetched, not yet retired instruction
//   o_pc           : current PC
//   o_pc_plus4     : o_pc + 4 (combinational, wraps modulo 2^32)
//   o_fetch_error  : sticky, a fetch timed out; cleared only by rst
// -----------------------------------------------------------------------------
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  mips_fetch_unit_if.master         imem,
  input  logic                      i_instr_done,
  input  logic                      i_branch,
  input  logic                      i_jump,
  input  logic                      i_zero,
  output logic [31:0]               o_opcode,
  output logic                      o_instr_valid,
  output logic [31:0]               o_pc,
  output logic [31:0]               o_pc_plus4,
  output logic                      o_fetch_error
);

  // Counter only has to reach MEM_TIMEOUT-1.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t             r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_imem_addr;
  logic               r_imem_req;
  logic [31:0]        r_opcode;
  logic               r_instr_valid;
  logic               r_fetch_error;
  logic [CNT_W-1:0]   r_cnt;

  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_next_pc;
  logic               w_timeout_hit;

  // Next-PC selection; jump outranks a taken branch.
  function automatic logic [31:0] f_next_pc(
    input logic [31:0] pc4,
    input logic [31:0] instr,
    input logic        branch,
    input logic        jump,
    input logic        zero
  );
    logic [31:0] w_br_off;
    w_br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    if (jump) begin
      f_next_pc = {pc4[31:28], instr[25:0], 2'b00};
    end else if (branch && zero) begin
      f_next_pc = pc4 + w_br_off;
    end else begin
      f_next_pc = pc4;
    end
  endfunction

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_next_pc     = f_next_pc(w_pc_plus4, r_opcode, i_branch, i_jump, i_zero);
  // The edge that sees counter == MEM_TIMEOUT-1 is the last allowed WAIT edge.
  assign w_timeout_hit = (MEM_TIMEOUT != 32'sd0) &&
                         (r_cnt == CNT_W'(MEM_TIMEOUT - 32'sd1));

  // Fetch FSM with all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_imem_addr   <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_opcode      <= 32'h0000_0000;
      r_instr_valid <= 1'b0;
      r_fetch_error <= 1'b0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_imem_req  <= 1'b1;
          r_imem_addr <= r_pc;
          r_cnt       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          // Ready on the timeout edge still completes the fetch.
          if (imem.imem_ready) begin
            r_opcode      <= imem.imem_rdata;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end else if (w_timeout_hit) begin
            r_imem_req    <= 1'b0;
            r_fetch_error <= 1'b1;
            r_state       <= S_ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          // Retire: issue the next fetch on the same edge, skipping FETCH.
          if (i_instr_done) begin
            r_pc          <= w_next_pc;
            r_imem_addr   <= w_next_pc;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
            r_cnt         <= '0;
            r_state       <= S_WAIT;
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_ERR: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_fetch_error <= 1'b1;
          r_state       <= S_ERR;
        end
        default: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_state       <= S_FETCH;
        end
      endcase
    end
  end

  assign imem.imem_req   = r_imem_req;
  assign imem.imem_addr  = r_imem_addr;
  assign o_opcode        = r_opcode;
  assign o_instr_valid   = r_instr_valid;
  assign o_pc            = r_pc;
  assign o_pc_plus4      = w_pc_plus4;
  assign o_fetch_error   = r_fetch_error;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_fetch_unit
// Directed bench for mips_fetch_unit (RESET_PC=0, MEM_TIMEOUT=4). A table of
// fetch/retire records walks the PC through sequential, jump and branch
// paths; hand-written sequences cover ignored inputs, async reset mid-WAIT
// and the fetch timeout.
// -----------------------------------------------------------------------------
module tb_mips_fetch_unit;

  logic        clk;
  logic        rst;
  logic        instr_done;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [31:0] opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_error;

  int n_cmp;
  int n_err;

  mips_fetch_unit_if imem_if();

  mips_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_if),
    .i_instr_done  (instr_done),
    .i_branch      (branch),
    .i_jump        (jump),
    .i_zero        (zero),
    .o_opcode      (opcode),
    .o_instr_valid (instr_valid),
    .o_pc          (pc),
    .o_pc_plus4    (pc_plus4),
    .o_fetch_error (fetch_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    int          delay;
    logic        jmp;
    logic        br;
    logic        zr;
    logic [31:0] next_pc;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    instr_done = 1'b0;
    branch = 1'b0;
    jump = 1'b0;
    zero = 1'b0;
    imem_if.imem_ready = 1'b0;
    imem_if.imem_rdata = 32'h0000_0000;

    //           pc             rdata          dly  J     B     Z     next pc
    vecs[0] = '{32'h0000_0000, 32'h8C22_0004, 2, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
    vecs[1] = '{32'h0000_0004, 32'h0800_0010, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0040};
    vecs[2] = '{32'h0000_0040, 32'h1000_FFFE, 1, 1'b0, 1'b1, 1'b1, 32'h0000_003C};
    vecs[3] = '{32'h0000_003C, 32'h1000_FFFE, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0040};
    vecs[4] = '{32'h0000_0040, 32'h1000_FFFE, 3, 1'b0, 1'b1, 1'b0, 32'h0000_0044};
    vecs[5] = '{32'h0000_0044, 32'h1000_0003, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0054};
    vecs[6] = '{32'h0000_0054, 32'h0BFF_FFFF, 1, 1'b1, 1'b0, 1'b0, 32'h0FFF_FFFC};
    vecs[7] = '{32'h0FFF_FFFC, 32'h0000_0020, 0, 1'b0, 1'b1, 1'b0, 32'h1000_0000};
    vecs[8] = '{32'h1000_0000, 32'h0800_0010, 2, 1'b1, 1'b1, 1'b1, 32'h1000_0040};
    vecs[9] = '{32'h1000_0040, 32'h1000_8000, 0, 1'b0, 1'b1, 1'b1, 32'h0FFE_0044};

    // Reset state
    tick();
    tick();
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_addr", imem_if.imem_addr, 32'h0000_0000);
    chk("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, fetch_error}, 32'd0);
    chk("rst_opcode", opcode, 32'h0000_0000);
    rst = 1'b0;
    chk("rel_req_before_edge", {31'd0, imem_if.imem_req}, 32'd0);
    tick();
    chk("first_req", {31'd0, imem_if.imem_req}, 32'd1);
    chk("first_addr", imem_if.imem_addr, 32'h0000_0000);

    // Table: fetch with delay, hold, retire
    for (int i = 0; i < 10; i++) begin
      imem_if.imem_ready = 1'b0;
      for (int d = 0; d < vecs[i].delay; d++) tick();
      chk("wait_req", {31'd0, imem_if.imem_req}, 32'd1);
      chk("wait_addr", imem_if.imem_addr, vecs[i].pc);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      imem_if.imem_rdata = vecs[i].rdata;
      imem_if.imem_ready = 1'b1;
      tick();
      imem_if.imem_ready = 1'b0;
      imem_if.imem_rdata = 32'hA5A5_A5A5;
      chk("fetch_opcode", opcode, vecs[i].rdata);
      chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
      chk("fetch_req", {31'd0, imem_if.imem_req}, 32'd0);
      chk("fetch_err", {31'd0, fetch_error}, 32'd0);
      chk("hold_pc", pc, vecs[i].pc);
      chk("hold_pc4", pc_plus4, vecs[i].pc + 32'd4);
      // Controls without retire must not move the PC
      jump = 1'b1;
      branch = 1'b1;
      zero = 1'b1;
      tick();
      chk("hold_stable_pc", pc, vecs[i].pc);
      chk("hold_stable_valid", {31'd0, instr_valid}, 32'd1);
      jump = vecs[i].jmp;
      branch = vecs[i].br;
      zero = vecs[i].zr;
      instr_done = 1'b1;
      tick();
      instr_done = 1'b0;
      jump = 1'b0;
      branch = 1'b0;
      zero = 1'b0;
      chk("retire_pc", pc, vecs[i].next_pc);
      chk("retire_addr", imem_if.imem_addr, vecs[i].next_pc);
      chk("retire_req", {31'd0, imem_if.imem_req}, 32'd1);
      chk("retire_valid", {31'd0, instr_valid}, 32'd0);
    end

    // instr_done during WAIT is ignored
    instr_done = 1'b1;
    jump = 1'b1;
    tick();
    instr_done = 1'b0;
    jump = 1'b0;
    chk("ign_done_pc", pc, 32'h0FFE_0044);
    chk("ign_done_req", {31'd0, imem_if.imem_req}, 32'd1);
    chk("ign_done_valid", {31'd0, instr_valid}, 32'd0);
    imem_if.imem_rdata = 32'h1234_5678;
    imem_if.imem_ready = 1'b1;
    tick();
    // imem_ready during HOLD is ignored
    imem_if.imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_if.imem_ready = 1'b0;
    chk("ign_rdy_opcode", opcode, 32'h1234_5678);
    chk("ign_rdy_valid", {31'd0, instr_valid}, 32'd1);
    chk("ign_rdy_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("ign_rdy_pc", pc, 32'h0FFE_0044);

    // Async reset mid-WAIT
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    chk("pre_arst_pc", pc, 32'h0FFE_0048);
    chk("pre_arst_req", {31'd0, imem_if.imem_req}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_pc", pc, 32'h0000_0000);
    chk("arst_addr", imem_if.imem_addr, 32'h0000_0000);
    #2;
    rst = 1'b0;
    tick();
    chk("arst_restart_req", {31'd0, imem_if.imem_req}, 32'd1);
    chk("arst_restart_addr", imem_if.imem_addr, 32'h0000_0000);

    // Timeout: no ready for 4 WAIT edges
    repeat (3) tick();
    chk("to_3_req", {31'd0, imem_if.imem_req}, 32'd1);
    chk("to_3_err", {31'd0, fetch_error}, 32'd0);
    tick();
    chk("to_4_err", {31'd0, fetch_error}, 32'd1);
    chk("to_4_req", {31'd0, imem_if.imem_req}, 32'd0);
    instr_done = 1'b1;
    imem_if.imem_ready = 1'b1;
    imem_if.imem_rdata = 32'h0BAD_F00D;
    repeat (3) tick();
    instr_done = 1'b0;
    imem_if.imem_ready = 1'b0;
    chk("err_sticky", {31'd0, fetch_error}, 32'd1);
    chk("err_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("err_valid", {31'd0, instr_valid}, 32'd0);
    chk("err_pc", pc, 32'h0000_0000);
    chk("err_opcode", opcode, 32'h0000_0000);
    rst = 1'b1;
    #1;
    chk("err_rst_clear", {31'd0, fetch_error}, 32'd0);
    chk("err_rst_pc", pc, 32'h0000_0000);
    #2;
    rst = 1'b0;
    tick();
    chk("err_rst_restart", {31'd0, imem_if.imem_req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
